// File: rtl/icache_pkg.sv
// Shared types and address-field helpers for the direct-mapped fetch cache.
// Field widths derive from LINES/WORDS; pc bits [1:0] never reach a field.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2
  } state_t;

  function automatic int offset_w(input int words);
    return $clog2(words);
  endfunction

  function automatic int index_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_w(input int lines, input int words);
    return 30 - $clog2(lines) - $clog2(words);
  endfunction

  function automatic logic [31:0] pc_offset(input logic [31:0] pc, input int words);
    return (pc >> 2) & 32'(words - 1);
  endfunction

  function automatic logic [31:0] pc_index(input logic [31:0] pc, input int lines, input int words);
    return (pc >> (2 + $clog2(words))) & 32'(lines - 1);
  endfunction

  function automatic logic [31:0] pc_tag(input logic [31:0] pc, input int lines, input int words);
    return pc >> (2 + $clog2(words) + $clog2(lines));
  endfunction

  function automatic logic [31:0] line_base(input logic [31:0] pc, input int words);
    return pc & ~32'(4 * words - 1);
  endfunction

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data register arrays: combinational read port, one-word-per-cycle write port.
// Zero read latency; the writer never stalls.
module icache_line_store
  import icache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [index_w(LINES)-1:0]        rd_index,
  input  logic [offset_w(WORDS)-1:0]       rd_offset,
  output logic                             rd_valid,
  output logic [tag_w(LINES, WORDS)-1:0]   rd_tag,
  output logic [31:0]                      rd_word,
  input  logic                             wr_en,
  input  logic                             wr_last,
  input  logic [index_w(LINES)-1:0]        wr_index,
  input  logic [offset_w(WORDS)-1:0]       wr_offset,
  input  logic [31:0]                      wr_data,
  input  logic [tag_w(LINES, WORDS)-1:0]   wr_tag
);

  localparam int TW = tag_w(LINES, WORDS);

  logic [LINES-1:0] valid;
  logic [TW-1:0]    tags [LINES];
  logic [31:0]      data [LINES][WORDS];

  // A line being refilled reads invalid until its last beat installs the tag.
  always_ff @(posedge clock) begin
    if (!reset) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_index] <= wr_last;
    end
  end

  always_ff @(posedge clock) begin
    if (reset && wr_en) begin
      data[wr_index][wr_offset] <= wr_data;
      if (wr_last) begin
        tags[wr_index] <= wr_tag;
      end
    end
  end

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tags[rd_index];
  assign rd_word  = data[rd_index][rd_offset];

endmodule

// File: rtl/icache_fetch.sv
// Direct-mapped I-cache on the fetch path: hits return in the PC cycle, misses stall.
// Refill waits on mem_gnt and advances one word per mem_rvalid; gaps simply extend the stall.
module icache_fetch
  import icache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        fetch_en,
  input  logic        flush,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int OW = offset_w(WORDS);
  localparam int IW = index_w(LINES);
  localparam int TW = tag_w(LINES, WORDS);

  state_t        state_q, state_d;
  logic [OW-1:0] beat_q;
  logic [31:0]   line_addr_q;
  logic [IW-1:0] idx_q;
  logic [TW-1:0] tag_q;

  logic [OW-1:0] pc_off;
  logic [IW-1:0] pc_idx;
  logic [TW-1:0] pc_tg;
  logic          rd_valid;
  logic [TW-1:0] rd_tag;
  logic [31:0]   rd_word;
  logic          lookup, hit, miss, last_beat, wr_en;

  // A redirect during refill needs no action: the line still installs and the
  // next IDLE cycle looks up the redirected pc, so the stale miss is never delivered.
  logic unused_flush;
  assign unused_flush = flush;

  assign pc_off = OW'(pc_offset(pc, WORDS));
  assign pc_idx = IW'(pc_index(pc, LINES, WORDS));
  assign pc_tg  = TW'(pc_tag(pc, LINES, WORDS));

  icache_line_store #(.LINES(LINES), .WORDS(WORDS)) u_store (
    .clock     (clock),
    .reset     (reset),
    .rd_index  (pc_idx),
    .rd_offset (pc_off),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_word   (rd_word),
    .wr_en     (wr_en),
    .wr_last   (last_beat),
    .wr_index  (idx_q),
    .wr_offset (beat_q),
    .wr_data   (mem_rdata),
    .wr_tag    (tag_q)
  );

  assign lookup    = (state_q == IDLE) && fetch_en && reset;
  assign hit       = lookup && rd_valid && (rd_tag == pc_tg);
  assign miss      = lookup && !hit;
  assign wr_en     = (state_q == FILL) && mem_rvalid;
  assign last_beat = (beat_q == OW'(WORDS - 1));

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (miss) state_d = REQ;
      REQ:     if (mem_gnt) state_d = FILL;
      FILL:    if (mem_rvalid && last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    instr       = hit ? rd_word : 32'h0;
    instr_valid = hit;
    stall       = miss || (state_q != IDLE);
    mem_req     = (state_q == REQ);
    mem_addr    = line_addr_q;
  end

  // Beat counter is OW bits wide, so it wraps to 0 after WORDS beats.
  always_ff @(posedge clock) begin
    if (!reset) begin
      beat_q      <= '0;
      line_addr_q <= '0;
      idx_q       <= '0;
      tag_q       <= '0;
    end else begin
      if (state_q == IDLE && miss) begin
        line_addr_q <= line_base(pc, WORDS);
        idx_q       <= pc_idx;
        tag_q       <= pc_tg;
      end
      if (wr_en) begin
        beat_q <= beat_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_icache_fetch.sv
// Directed bench for icache_fetch: cold miss, hits, eviction, flush, slow handshake, reset.
module tb_icache_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        fetch_en;
  logic        flush;
  logic [31:0] instr;
  logic        instr_valid;
  logic        stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  icache_fetch #(.LINES(16), .WORDS(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .pc          (pc),
    .fetch_en    (fetch_en),
    .flush       (flush),
    .instr       (instr),
    .instr_valid (instr_valid),
    .stall       (stall),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge; inputs are driven there.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Called in the miss cycle (cycle 0) after inputs are set; returns at cycle b+1.
  task automatic refill(input logic [31:0] exp_addr, input int gnt_wait, input int gap,
                        input logic [31:0] d0, input int flush_beat, input logic [31:0] flush_pc);
    #1;
    chk("miss_stall", {31'b0, stall}, 32'd1);
    chk("miss_no_req", {31'b0, mem_req}, 32'd0);
    cyc();
    for (int w = 0; w <= gnt_wait; w++) begin
      mem_gnt = (w == gnt_wait);
      #1;
      chk("req_high", {31'b0, mem_req}, 32'd1);
      chk("req_addr", mem_addr, exp_addr);
      chk("req_stall", {31'b0, stall}, 32'd1);
      cyc();
    end
    mem_gnt = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (b > 0) begin
        for (int g = 0; g < gap; g++) begin
          mem_rvalid = 1'b0;
          #1;
          chk("gap_stall", {31'b0, stall}, 32'd1);
          cyc();
        end
      end
      mem_rvalid = 1'b1;
      mem_rdata  = d0 + 32'(b);
      flush      = (b == flush_beat);
      if (b == flush_beat) pc = flush_pc;
      #1;
      chk("beat_stall", {31'b0, stall}, 32'd1);
      chk("beat_no_req", {31'b0, mem_req}, 32'd0);
      cyc();
    end
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    flush      = 1'b0;
  endtask

  task automatic expect_hit(input string tag, input logic [31:0] addr, input logic [31:0] word);
    pc = addr;
    #1;
    chk({tag, "_instr"}, instr, word);
    chk({tag, "_valid"}, {31'b0, instr_valid}, 32'd1);
    chk({tag, "_stall"}, {31'b0, stall}, 32'd0);
    chk({tag, "_req"},   {31'b0, mem_req}, 32'd0);
    cyc();
  endtask

  initial begin
    reset = 1'b0; pc = 32'h40; fetch_en = 1'b1; flush = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    cyc();
    cyc();
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_req",   {31'b0, mem_req}, 32'd0);
    chk("rst_addr",  mem_addr, 32'h0);

    // Cold miss at 0x40, grant in cycle 1, back-to-back beats.
    reset = 1'b1;
    refill(32'h40, 0, 0, 32'hA0, -1, 32'h0);
    expect_hit("cold", 32'h40, 32'hA0);
    expect_hit("seq1", 32'h44, 32'hA1);
    expect_hit("seq2", 32'h48, 32'hA2);
    expect_hit("seq3", 32'h4C, 32'hA3);

    // No fetch: no lookup, no miss; flush in IDLE leaves hits intact.
    pc = 32'h300; fetch_en = 1'b0;
    #1;
    chk("nofetch_stall", {31'b0, stall}, 32'd0);
    chk("nofetch_instr", instr, 32'h0);
    cyc();
    fetch_en = 1'b1; flush = 1'b1;
    expect_hit("idle_flush", 32'h44, 32'hA1);
    flush = 1'b0;

    // Conflict eviction on index 4.
    pc = 32'h140;
    refill(32'h140, 0, 0, 32'hB0, -1, 32'h0);
    expect_hit("evict_new", 32'h14C, 32'hB3);
    pc = 32'h40;
    refill(32'h40, 0, 0, 32'hA0, -1, 32'h0);
    expect_hit("evict_back", 32'h40, 32'hA0);

    // Flush during beat 2 of a miss at 0x80, redirected to cached 0x40.
    pc = 32'h80;
    refill(32'h80, 0, 0, 32'hC0, 2, 32'h40);
    expect_hit("flush_redir", 32'h40, 32'hA0);
    expect_hit("flush_inst", 32'h88, 32'hC2);

    // Grant withheld 3 cycles, one idle cycle between beats.
    pc = 32'hC4;
    refill(32'hC0, 3, 1, 32'hD0, -1, 32'h0);
    expect_hit("slow_w1", 32'hC4, 32'hD1);
    expect_hit("slow_w0", 32'hC0, 32'hD0);
    expect_hit("slow_w2", 32'hC8, 32'hD2);
    expect_hit("slow_w3", 32'hCC, 32'hD3);

    // Reset after beat 1 of a miss at 0x100.
    pc = 32'h100;
    #1;
    chk("rmid_miss", {31'b0, stall}, 32'd1);
    cyc();
    mem_gnt = 1'b1;
    cyc();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hE0;
    cyc();
    mem_rdata = 32'hE1;
    cyc();
    mem_rvalid = 1'b0; reset = 1'b0;
    cyc();
    chk("rmid_instr", instr, 32'h0);
    chk("rmid_valid", {31'b0, instr_valid}, 32'd0);
    chk("rmid_stall", {31'b0, stall}, 32'd0);
    chk("rmid_req",   {31'b0, mem_req}, 32'd0);
    chk("rmid_addr",  mem_addr, 32'h0);
    reset = 1'b1;
    refill(32'h100, 0, 0, 32'hF0, -1, 32'h0);
    expect_hit("rmid_refetch", 32'h104, 32'hF1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/icache_fetch.md
# icache_fetch

Direct-mapped instruction cache inserted between the PC register and the IF/ID pipeline register of the 5-stage pipelined CPU, replacing the combinational instruction memory on the fetch path. Hits return the instruction combinationally in the same cycle as the PC, preserving single-cycle IF timing. Misses assert `stall` into the PCWrite/IF_ID_WriteEn hazard logic and run a line-refill state machine against a slower backing memory with a request/grant and beat handshake.

## Interface
- `LINES`, 16: number of cache lines, power of two.
- `WORDS`, 4: 32-bit words per line, power of two, at least 2.
- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-low; sampled on the rising edge.
- `pc`  in  32: fetch address; bits [1:0] are ignored.
- `fetch_en`  in  1: fetch requested this cycle; low means no lookup and no miss.
- `flush`  in  1: branch/jump redirect; cancels delivery of a pending miss.
- `instr`  out  32: fetched instruction; 0 (nop) when `instr_valid` is low.
- `instr_valid`  out  1: `instr` is a hit for the current `pc`.
- `stall`  out  1: freeze PC and IF/ID this cycle.
- `mem_req`  out  1: line-refill request.
- `mem_addr`  out  32: line-aligned refill address, low log2(WORDS)+2 bits zero.
- `mem_gnt`  in  1: request accepted in a cycle where `mem_req` is high.
- `mem_rvalid`  in  1: refill data beat valid.
- `mem_rdata`  in  32: beat data, words in ascending order.

## Operation
- Address split: offset = pc[log2(WORDS)+1:2], index = next log2(LINES) bits, tag = remaining upper bits. Defaults: offset [3:2], index [7:4], tag [31:8].
- Storage: per line one valid bit, one tag, and WORDS data words.
- States: IDLE, REQ, FILL.
- IDLE: hit = fetch_en & valid[index] & tag match. On a hit: `instr` = word, `instr_valid`=1, `stall`=0. On a miss with fetch_en=1: `stall`=1, latch line address and index, go to REQ.
- REQ: `mem_req`=1 and `mem_addr` is held stable until `mem_gnt`, then go to FILL. `stall`=1.
- FILL: each `mem_rvalid` writes `mem_rdata` to word[beat count] of the latched index; the beat counter wraps after WORDS beats. The last beat writes the tag, sets valid, and returns to IDLE. `stall`=1 throughout.
- When FILL completes, the next IDLE cycle re-looks up `pc` and hits if the PC is unchanged.
- `flush` in REQ or FILL: the refill still completes and the line is installed, since backing-memory transactions cannot be aborted. The latched "deliver" flag clears. `stall` stays high until IDLE. The redirected `pc` is then looked up normally.
- `flush` in IDLE: no state effect.
- `mem_rvalid` in IDLE or REQ is ignored.
- Reset (`reset`=0): all valid bits clear, state becomes IDLE, beat counter 0. Data and tag arrays are not cleared.
- Output reset values: `instr`=0, `instr_valid`=0, `stall`=0, `mem_req`=0, `mem_addr`=0.
- Reset mid-refill abandons the refill; the partially written line stays invalid.
- Beats arriving after reset while in IDLE are ignored. The backing memory shares this reset.

## Timing
- Hit: zero added latency. `instr` and `instr_valid` are combinational from `pc` and the arrays.
- Miss, with grant at cycle g and last beat at cycle b:
  - cycle 0: miss detected, `stall`=1.
  - cycle 1: `mem_req`=1.
  - cycle g: grant.
  - cycles g+1..b: beats.
  - cycle b+1: IDLE, hit, `stall`=0.
- Minimum miss penalty (grant at cycle 1, back-to-back beats): WORDS+2 stalled cycles. Default: 6.
- `stall` is combinational in IDLE (from miss detection) and registered-state driven in REQ/FILL.
- `mem_req` is registered-state driven only, with no combinational path from `mem_gnt`.
- Gaps between beats are allowed; the beat counter advances only on `mem_rvalid`.

## Structure
- Shared package `icache_pkg`:
  - state enum constants (IDLE=2'd0, REQ=2'd1, FILL=2'd2);
  - derived field widths (OFFSET_W, INDEX_W, TAG_W) as functions of LINES/WORDS;
  - field-extract helpers.
- Sub-module `icache_line_store`: tag/valid/data register arrays with a combinational read port and a one-word-per-cycle write port plus tag/valid write. The FSM, hit logic and memory handshake live in `icache_fetch`.

## Test plan
- Cold miss: reset, pc=0x00000040, fetch_en=1, grant at cycle 1, beats 0xA0..0xA3 back-to-back.
  - Expected: `stall` high for cycles 0-5; `mem_addr`=0x40; at cycle 6 `instr`=0xA0, `instr_valid`=1.
- Sequential hits: after the fill, pc 0x44, 0x48, 0x4C.
  - Expected: `instr` 0xA1, 0xA2, 0xA3; `stall`=0; `mem_req` never asserted.
- Conflict eviction: fill pc=0x40, then pc=0x140 (same index 4, different tag).
  - Expected: second miss refills index 4; returning to 0x40 misses again.
- Flush mid-fill: miss at 0x80, assert `flush` during beat 2, then change pc to 0x40 (already cached).
  - Expected: fill completes; `stall` drops the cycle after the last beat; 0x40 hits; 0x80 later hits without a refill.
- Delayed handshake: `mem_gnt` held low 3 cycles, then 1-cycle gaps between beats.
  - Expected: `mem_addr` stable while `mem_req` is high; all 4 words written correctly; `stall` high through the last beat.
- Reset mid-refill: `reset`=0 after beat 1.
  - Expected: next cycle all outputs at reset values, state IDLE; the same pc misses again on refetch.
